// File: rtl/usb_ep0_desc_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : usb_pkg
//  Description : Shared types and constants for the EP0 descriptor sequencer:
//                FSM state encoding, standard descriptor type codes and the
//                default EP0 max packet size.
//  Revision    : 1.0 - initial release
// ============================================================================
package usb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CHECK   = 3'd1,
        ST_WAIT_IN = 3'd2,
        ST_SEND    = 3'd3,
        ST_END     = 3'd4,
        ST_WAIT_HS = 3'd5,
        ST_STATUS  = 3'd6,
        ST_STALL   = 3'd7
    } ep0_state_t;

    localparam logic [7:0] DESC_DEVICE     = 8'h01;
    localparam logic [7:0] DESC_CONFIG     = 8'h02;
    localparam logic [7:0] DESC_STRING     = 8'h03;
    localparam logic [7:0] DESC_HID_REPORT = 8'h22;

    localparam int EP0_MAX_PKT = 8;

endpackage
`default_nettype wire

// File: rtl/usb_ep0_desc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : usb_ep0_desc_sequencer
//  Description : Data-stage sequencer for EP0 GET_DESCRIPTOR control reads.
//                Addresses an external combinational descriptor ROM, splits
//                the descriptor into MAX_PKT-byte IN packets, tracks the
//                DATA0/DATA1 toggle, retransmits on handshake timeout, and
//                emits a ZLP or a STALL where required.
//  Ports       : clk, rst (async, active high)
//                setup_*      - decoded GET_DESCRIPTOR setup (pulse + fields)
//                in_token, ack_rcvd, hs_timeout, status_done - bus events
//                rom_*        - descriptor ROM address/length out, data in
//                tx_*         - packet transmitter interface
//                busy         - high whenever a transfer is in progress
//  Revision    : 1.0 - initial release
// ============================================================================
module usb_ep0_desc_sequencer
    import usb_pkg::*;
#(
    parameter int MAX_PKT = EP0_MAX_PKT,
    parameter int LEN_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             setup_valid,
    input  logic [7:0]       setup_type,
    input  logic [7:0]       setup_index,
    input  logic [LEN_W-1:0] setup_length,
    input  logic             in_token,
    input  logic             ack_rcvd,
    input  logic             hs_timeout,
    input  logic             status_done,
    output logic [7:0]       rom_type,
    output logic [7:0]       rom_index,
    output logic [LEN_W-1:0] rom_byte_index,
    output logic [LEN_W-1:0] rom_req_len,
    input  logic [7:0]       rom_data,
    input  logic             rom_valid,
    output logic             tx_start,
    output logic             tx_pid_data1,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             tx_end,
    output logic             tx_stall,
    output logic             busy
);

    localparam int              CNT_W = $clog2(MAX_PKT + 1);
    localparam logic [CNT_W-1:0] C_MAX_CNT = CNT_W'(MAX_PKT);

    ep0_state_t       r_state,   w_state_nxt;
    logic [7:0]       r_type,    w_type_nxt;
    logic [7:0]       r_index,   w_index_nxt;
    logic [LEN_W-1:0] r_req_len, w_req_len_nxt;
    logic [LEN_W-1:0] r_base,    w_base_nxt;
    logic [CNT_W-1:0] r_cnt,     w_cnt_nxt;
    logic             r_pid,     w_pid_nxt;

    logic [LEN_W-1:0] w_sum;
    logic             w_full;

    // Byte currently addressed: start of this packet plus bytes sent so far.
    // After the packet this is also the start of the next one.
    assign w_sum  = r_base + LEN_W'(r_cnt);
    assign w_full = (r_cnt == C_MAX_CNT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_type    <= '0;
            r_index   <= '0;
            r_req_len <= '0;
            r_base    <= '0;
            r_cnt     <= '0;
            r_pid     <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_type    <= w_type_nxt;
            r_index   <= w_index_nxt;
            r_req_len <= w_req_len_nxt;
            r_base    <= w_base_nxt;
            r_cnt     <= w_cnt_nxt;
            r_pid     <= w_pid_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_type_nxt    = r_type;
        w_index_nxt   = r_index;
        w_req_len_nxt = r_req_len;
        w_base_nxt    = r_base;
        w_cnt_nxt     = r_cnt;
        w_pid_nxt     = r_pid;
        tx_start      = 1'b0;
        tx_valid      = 1'b0;
        tx_data       = 8'h00;
        tx_end        = 1'b0;
        tx_stall      = 1'b0;

        // A new setup wins over everything: any in-flight packet is dropped
        // without tx_end and the transfer restarts from byte 0 as DATA1.
        if (setup_valid) begin
            w_type_nxt    = setup_type;
            w_index_nxt   = setup_index;
            w_req_len_nxt = setup_length;
            w_base_nxt    = '0;
            w_cnt_nxt     = '0;
            w_pid_nxt     = 1'b1;
            w_state_nxt   = ST_CHECK;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                end
                ST_CHECK: begin
                    // Byte 0 is addressed here, so rom_valid tells whether
                    // the requested descriptor exists at all.
                    if (r_req_len == '0) begin
                        w_state_nxt = ST_STATUS;
                    end else if (!rom_valid) begin
                        w_state_nxt = ST_STALL;
                    end else begin
                        w_state_nxt = ST_WAIT_IN;
                    end
                end
                ST_WAIT_IN: begin
                    if (in_token) begin
                        tx_start    = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_SEND;
                    end
                end
                ST_SEND: begin
                    tx_data = rom_data;
                    // An empty ROM at packet start yields a zero-length packet.
                    if (!rom_valid || w_full) begin
                        w_state_nxt = ST_END;
                    end else begin
                        tx_valid = 1'b1;
                        if (tx_ready) begin
                            w_cnt_nxt = r_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_END: begin
                    tx_end      = 1'b1;
                    w_state_nxt = ST_WAIT_HS;
                end
                ST_WAIT_HS: begin
                    // r_cnt is held here so a timeout can resend the same
                    // packet from r_base; ACK takes priority over timeout.
                    if (ack_rcvd) begin
                        w_base_nxt = w_sum;
                        w_pid_nxt  = ~r_pid;
                        if (!w_full || (w_sum == r_req_len)) begin
                            w_state_nxt = ST_STATUS;
                        end else begin
                            w_state_nxt = ST_WAIT_IN;
                        end
                    end else if (hs_timeout) begin
                        w_state_nxt = ST_WAIT_IN;
                    end
                end
                ST_STATUS: begin
                    if (status_done) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_STALL: begin
                    if (in_token) begin
                        tx_stall = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    assign rom_type       = r_type;
    assign rom_index      = r_index;
    assign rom_req_len    = r_req_len;
    assign rom_byte_index = w_sum;
    assign tx_pid_data1   = r_pid;
    assign busy           = (r_state != ST_IDLE);

endmodule
`default_nettype wire
